// File: rtl/div32u_seq_trunc.sv
// div32u_seq_trunc: iterative 32/16 unsigned restoring divider, one quotient bit per clock, optional truncated LSB iterations
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   in_valid/ready   operand handshake; A = 32-bit dividend, B = 16-bit divisor
//   out_valid/ready  result handshake; Q quotient, R remainder, OVF quotient overflow, DBZ divide by zero
module div32u_seq_trunc #(
    parameter int TRUNC_BITS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [15:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Q,
    output logic [15:0] R,
    output logic        OVF,
    output logic        DBZ
);
    localparam int N = 16 - TRUNC_BITS;

    // LOAD is the cycle after accept that classifies the latched operands
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state, nxt;

    logic [31:0] d;
    logic [15:0] v;
    logic [15:0] p;
    logic [15:0] dl;
    logic [14:0] qw;
    logic [4:0]  cnt;
    logic [16:0] t;
    logic        qbit;
    logic [15:0] p_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = in_valid ? LOAD : IDLE;
            LOAD: nxt = (v == 16'd0 || d[31:16] >= v) ? DONE : RUN;
            RUN:  nxt = (cnt == 5'd1) ? DONE : RUN;
            DONE: nxt = out_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end

    // Partial remainder stays below V, so 16 bits hold it; T needs the 17th bit
    always_comb begin
        t    = {p, dl[15]};
        qbit = t >= {1'b0, v};
        p_nx = qbit ? 16'(t - {1'b0, v}) : t[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d   <= '0;
            v   <= '0;
            p   <= '0;
            dl  <= '0;
            qw  <= '0;
            cnt <= '0;
            Q   <= '0;
            R   <= '0;
            OVF <= 1'b0;
            DBZ <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            d <= A;
            v <= B;
        end else if (state == LOAD) begin
            if (v == 16'd0 || d[31:16] >= v) begin
                Q   <= 16'hFFFF;
                R   <= '0;
                DBZ <= v == 16'd0;
                OVF <= v != 16'd0;
            end else begin
                p   <= d[31:16];
                dl  <= d[15:0];
                qw  <= '0;
                cnt <= 5'(N);
            end
        end else if (state == RUN) begin
            p   <= p_nx;
            dl  <= {dl[14:0], 1'b0};
            qw  <= {qw[13:0], qbit};
            cnt <= cnt - 5'd1;
            if (cnt == 5'd1) begin
                // Skipped iterations leave the quotient LSBs at zero
                Q   <= 16'({qw, qbit} << TRUNC_BITS);
                R   <= p_nx;
                OVF <= 1'b0;
                DBZ <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_div32u_seq_trunc.sv
// tb_div32u_seq_trunc: directed and model-checked bench for div32u_seq_trunc at TRUNC_BITS 0 and 4
module tb_div32u_seq_trunc;
    logic        clk, rst, in_valid, out_ready;
    logic [31:0] A;
    logic [15:0] B;
    logic        ir0, ov0, ovf0, dbz0, ir4, ov4, ovf4, dbz4;
    logic [15:0] q0, r0, q4, r4;
    int          n_chk = 0, n_fail = 0;
    int          lat0, lat4;

    div32u_seq_trunc dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .A(A), .B(B),
        .out_valid(ov0), .out_ready(out_ready), .Q(q0), .R(r0), .OVF(ovf0), .DBZ(dbz0)
    );

    div32u_seq_trunc #(.TRUNC_BITS(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .A(A), .B(B),
        .out_valid(ov4), .out_ready(out_ready), .Q(q4), .R(r4), .OVF(ovf4), .DBZ(dbz4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [15:0] b);
        @(negedge clk);
        check("in_ready0", 32'(ir0), 32'd1);
        check("in_ready4", 32'(ir4), 32'd1);
        A = a;
        B = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        A = $urandom;
        B = 16'($urandom);
        lat0 = 0;
        lat4 = 0;
        for (int c = 1; c <= 40 && (lat0 == 0 || lat4 == 0); c++) begin
            @(negedge clk);
            if (ov0 && lat0 == 0) lat0 = c;
            if (ov4 && lat4 == 0) lat4 = c;
        end
    endtask

    task automatic release_out(input int delay);
        repeat (delay) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("rel_ov0", 32'(ov0), 32'd0);
        check("rel_ov4", 32'(ov4), 32'd0);
    endtask

    task automatic model(input logic [31:0] a, input logic [15:0] b, input int tb,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic o, output logic z, output int l);
        logic [31:0] dt;
        dt = a >> tb;
        if (b == 16'd0) begin
            q = 16'hFFFF; r = 16'd0; o = 1'b0; z = 1'b1; l = 1;
        end else if (a[31:16] >= b) begin
            q = 16'hFFFF; r = 16'd0; o = 1'b1; z = 1'b0; l = 1;
        end else begin
            q = 16'((dt / {16'd0, b}) << tb);
            r = 16'(dt % {16'd0, b});
            o = 1'b0; z = 1'b0; l = 17 - tb;
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [15:0] rb, hi, eq, er;
        logic        eo, ez;
        int          el, sel;
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b0;
        A = 32'd100000;
        B = 16'd300;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(ir0), 32'd1);
        check("rst_out_valid", 32'(ov0), 32'd0);
        check("rst_q", 32'(q0), 32'd0);
        check("rst_r", 32'(r0), 32'd0);
        check("rst_flags", 32'({ovf0, dbz0}), 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(ir0), 32'd1);

        run_op(32'd100000, 16'd300);
        check("t0_lat", 32'(lat0), 32'd17);
        check("t0_q", 32'(q0), 32'd333);
        check("t0_r", 32'(r0), 32'd100);
        check("t0_flags", 32'({ovf0, dbz0}), 32'd0);
        check("t4_lat", 32'(lat4), 32'd13);
        check("t4_q", 32'(q4), 32'd320);
        check("t4_r", 32'(r4), 32'd250);
        in_valid = 1'b1;
        A = 32'd5;
        B = 16'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_ov", 32'(ov0), 32'd1);
            check("hold_ir", 32'(ir0), 32'd0);
            check("hold_q", 32'(q0), 32'd333);
            check("hold_r", 32'(r0), 32'd100);
            check("hold_flags", 32'({ovf0, dbz0}), 32'd0);
            check("hold_q4", 32'(q4), 32'd320);
        end
        in_valid = 1'b0;
        release_out(0);
        check("keep_q", 32'(q0), 32'd333);
        check("keep_ir", 32'(ir0), 32'd1);

        run_op(32'h0005_0000, 16'd5);
        check("ovf_lat0", 32'(lat0), 32'd1);
        check("ovf_lat4", 32'(lat4), 32'd1);
        check("ovf_q", 32'(q0), 32'hFFFF);
        check("ovf_r", 32'(r0), 32'd0);
        check("ovf_flags", 32'({ovf0, dbz0}), 32'b10);
        check("ovf_flags4", 32'({ovf4, dbz4}), 32'b10);
        release_out(1);

        run_op(32'd123, 16'd0);
        check("dbz_lat", 32'(lat0), 32'd1);
        check("dbz_q", 32'(q0), 32'hFFFF);
        check("dbz_r", 32'(r0), 32'd0);
        check("dbz_flags", 32'({ovf0, dbz0}), 32'b01);
        release_out(0);

        run_op(32'hFFFE_0001, 16'hFFFF);
        check("max_lat", 32'(lat0), 32'd17);
        check("max_q", 32'(q0), 32'hFFFF);
        check("max_r", 32'(r0), 32'd0);
        check("max_q4", 32'(q4), 32'hFFF0);
        check("max_r4", 32'(r4), 32'hEFFF);
        release_out(0);
        run_op(32'd7, 16'd2);
        check("b2b_q", 32'(q0), 32'd3);
        check("b2b_r", 32'(r0), 32'd1);
        check("b2b_q4", 32'(q4), 32'd0);
        check("b2b_r4", 32'(r4), 32'd0);
        release_out(0);

        @(negedge clk);
        A = 32'd100000;
        B = 16'd300;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy", 32'(ir0), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ir", 32'(ir0), 32'd1);
        check("mid_rst_ov", 32'(ov0), 32'd0);
        check("mid_rst_q", 32'(q0), 32'd0);
        check("mid_rst_r", 32'(r0), 32'd0);
        check("mid_rst_flags", 32'({ovf0, dbz0}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'd10, 16'd3);
        check("after_rst_lat", 32'(lat0), 32'd17);
        check("after_rst_q", 32'(q0), 32'd3);
        check("after_rst_r", 32'(r0), 32'd1);
        release_out(0);

        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            rb = sel == 0 ? 16'd0 : 16'($urandom_range(1, 65535));
            hi = sel == 0 ? 16'($urandom) :
                 sel == 1 ? 16'($urandom_range(rb, 65535)) : 16'($urandom_range(0, rb - 1));
            ra = {hi, 16'($urandom)};
            run_op(ra, rb);
            model(ra, rb, 0, eq, er, eo, ez, el);
            check("rnd_lat0", 32'(lat0), 32'(el));
            check("rnd_q0", 32'(q0), 32'(eq));
            check("rnd_r0", 32'(r0), 32'(er));
            check("rnd_flags0", 32'({ovf0, dbz0}), 32'({eo, ez}));
            model(ra, rb, 4, eq, er, eo, ez, el);
            check("rnd_lat4", 32'(lat4), 32'(el));
            check("rnd_q4", 32'(q4), 32'(eq));
            check("rnd_r4", 32'(r4), 32'(er));
            check("rnd_flags4", 32'({ovf4, dbz4}), 32'({eo, ez}));
            release_out($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
